fetch_sequencer: RTL and testbench

//   Fetch-stage controller that sequences the program-counter register and the instruction-memory handshake.
//   It computes next_pc and pc_stall for the PC register.
//   It arbitrates between sequential fetch, EX-stage redirects (branch/jump), load-use hazard stalls and imem wait states.
//   It generates IF/ID hold and pipeline flush/bubble controls.

---
 rtl/fetch_seq_pkg.sv | 15 +
 rtl/fetch_seq_perf.sv | 39 +++
 rtl/fetch_sequencer.sv | 147 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_seq_pkg.sv
// Shared types and defaults for the fetch-stage sequencer.
// Optional perf counters are enabled with FETCH_SEQ_PERF_EN.
package fetch_seq_pkg;

    localparam int PC_W_DEF    = 16;
    localparam int PC_STEP_DEF = 4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_seq_perf.sv
// Saturating stall / redirect event counters for the fetch sequencer.
// Only instantiated when FETCH_SEQ_PERF_EN is defined.
module fetch_seq_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    output logic [15:0] stall_cnt_o,
    output logic [15:0] redirect_cnt_o
);

    logic [15:0] stall_q, stall_d;
    logic [15:0] redir_q, redir_d;

    always_comb begin
        stall_d = stall_q;
        redir_d = redir_q;
        if (stall_i && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
        if (redirect_i && (redir_q != 16'hFFFF)) begin
            redir_d = redir_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            redir_q <= '0;
        end else begin
            stall_q <= stall_d;
            redir_q <= redir_d;
        end
    end

    assign stall_cnt_o    = stall_q;
    assign redirect_cnt_o = redir_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage PC / imem handshake controller (BOOT, RUN, WAIT, DRAIN).
// Define FETCH_SEQ_PERF_EN to add stall_cnt / redirect_cnt outputs.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int PC_STEP     = PC_STEP_DEF,
    parameter int BOOT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] current_pc,
    input  logic            imem_ready,
    input  logic            hazard_stall,
    input  logic            redirect_vld,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] next_pc,
    output logic            pc_stall,
    output logic            imem_req,
    output logic            fetch_valid,
    output logic            if_id_stall,
    output logic            if_id_flush,
    output logic            id_ex_flush
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [15:0]     stall_cnt,
    output logic [15:0]     redirect_cnt
`endif
);

    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pend_pc_q, pend_pc_d;
    logic [BW-1:0]   boot_cnt_q, boot_cnt_d;
    logic [PC_W-1:0] seq_pc;
    logic            boot_done;

    assign seq_pc    = current_pc + PC_W'(PC_STEP);
    assign boot_done = (boot_cnt_q == BW'(BOOT_CYCLES - 1));

    always_comb begin
        state_d     = state_q;
        pend_pc_d   = pend_pc_q;
        boot_cnt_d  = boot_cnt_q;
        next_pc     = current_pc;
        pc_stall    = 1'b1;
        imem_req    = 1'b0;
        fetch_valid = 1'b0;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;

        unique case (state_q)
            BOOT: begin
                if (boot_done) begin
                    state_d = RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q + BW'(1);
                end
            end
            RUN, WAIT: begin
                imem_req = 1'b1;
                if (redirect_vld) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    // A miss still outstanding must be drained first
                    if (imem_ready || (state_q == RUN)) begin
                        next_pc  = redirect_pc;
                        pc_stall = 1'b0;
                        state_d  = RUN;
                    end else begin
                        pend_pc_d = redirect_pc;
                        state_d   = DRAIN;
                    end
                end else if (hazard_stall) begin
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                    if (imem_ready) begin
                        state_d = RUN;
                    end
                end else if (imem_ready) begin
                    next_pc     = seq_pc;
                    pc_stall    = 1'b0;
                    fetch_valid = 1'b1;
                    state_d     = RUN;
                end else begin
                    state_d = WAIT;
                end
            end
            DRAIN: begin
                imem_req = 1'b1;
                if (redirect_vld) begin
                    pend_pc_d   = redirect_pc;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end
                if (imem_ready) begin
                    next_pc  = redirect_vld ? redirect_pc : pend_pc_q;
                    pc_stall = 1'b0;
                    state_d  = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        if (rst) begin
            next_pc     = '0;
            pc_stall    = 1'b1;
            imem_req    = 1'b0;
            fetch_valid = 1'b0;
            if_id_stall = 1'b0;
            if_id_flush = 1'b0;
            id_ex_flush = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            pend_pc_q  <= '0;
            boot_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pend_pc_q  <= pend_pc_d;
            boot_cnt_q <= boot_cnt_d;
        end
    end

`ifdef FETCH_SEQ_PERF_EN
    logic count_stall;

    assign count_stall = pc_stall && (state_q != BOOT);

    fetch_seq_perf u_perf (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (count_stall),
        .redirect_i     (redirect_vld),
        .stall_cnt_o    (stall_cnt),
        .redirect_cnt_o (redirect_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized + directed bench for fetch_sequencer against a flag-based model.
// Perf counter checks are compiled in when FETCH_SEQ_PERF_EN is defined.
module tb_fetch_sequencer;

    localparam int PC_W        = 16;
    localparam int PC_STEP     = 4;
    localparam int BOOT_CYCLES = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [PC_W-1:0] current_pc;
    logic            imem_ready;
    logic            hazard_stall;
    logic            redirect_vld;
    logic [PC_W-1:0] redirect_pc;
    logic [PC_W-1:0] next_pc;
    logic            pc_stall;
    logic            imem_req;
    logic            fetch_valid;
    logic            if_id_stall;
    logic            if_id_flush;
    logic            id_ex_flush;
`ifdef FETCH_SEQ_PERF_EN
    logic [15:0]     stall_cnt;
    logic [15:0]     redirect_cnt;
`endif

    always #5 clk = ~clk;

    fetch_sequencer #(
        .PC_W        (PC_W),
        .PC_STEP     (PC_STEP),
        .BOOT_CYCLES (BOOT_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .current_pc   (current_pc),
        .imem_ready   (imem_ready),
        .hazard_stall (hazard_stall),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc),
        .next_pc      (next_pc),
        .pc_stall     (pc_stall),
        .imem_req     (imem_req),
        .fetch_valid  (fetch_valid),
        .if_id_stall  (if_id_stall),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush)
`ifdef FETCH_SEQ_PERF_EN
        ,
        .stall_cnt    (stall_cnt),
        .redirect_cnt (redirect_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Model: boot cycles left, fetch miss outstanding, discard pending
    int              m_boot  = 0;
    bit              m_miss  = 0;
    bit              m_drain = 0;
    logic [PC_W-1:0] m_pend  = '0;
    logic [PC_W-1:0] m_pc    = '0;
    int              m_scnt  = 0;
    int              m_rcnt  = 0;

    task automatic cyc(input bit r, input bit rdy, input bit haz,
                       input bit rv, input logic [PC_W-1:0] rpc,
                       input string tag);
        logic [PC_W-1:0] e_next;
        bit e_stall, e_req, e_fv, e_ifs, e_iff, e_ief;
        bit booting;

        rst          = r;
        imem_ready   = rdy;
        hazard_stall = haz;
        redirect_vld = rv;
        redirect_pc  = rpc;
        current_pc   = m_pc;

        e_next  = m_pc;
        e_stall = 1;
        e_req   = 0;
        e_fv    = 0;
        e_ifs   = 0;
        e_iff   = 0;
        e_ief   = 0;
        booting = (m_boot > 0);

        if (r) begin
            e_next = '0;
        end else if (booting) begin
            m_boot--;
        end else if (m_drain) begin
            e_req = 1;
            if (rv) begin
                m_pend = rpc;
                e_iff  = 1;
                e_ief  = 1;
            end
            if (rdy) begin
                e_next  = m_pend;
                e_stall = 0;
                m_drain = 0;
            end
        end else begin
            e_req = 1;
            if (rv) begin
                e_iff = 1;
                e_ief = 1;
                if (rdy || !m_miss) begin
                    e_next  = rpc;
                    e_stall = 0;
                end else begin
                    m_pend  = rpc;
                    m_drain = 1;
                end
                m_miss = 0;
            end else if (haz) begin
                e_ifs = 1;
                e_ief = 1;
                if (rdy) m_miss = 0;
            end else if (rdy) begin
                e_next  = m_pc + PC_W'(PC_STEP);
                e_stall = 0;
                e_fv    = 1;
                m_miss  = 0;
            end else begin
                m_miss = 1;
            end
        end

        @(negedge clk);
        chk({tag, ".next_pc"}, 32'(next_pc), 32'(e_next));
        chk({tag, ".pc_stall"}, 32'(pc_stall), 32'(e_stall));
        chk({tag, ".imem_req"}, 32'(imem_req), 32'(e_req));
        chk({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(e_fv));
        chk({tag, ".if_id_stall"}, 32'(if_id_stall), 32'(e_ifs));
        chk({tag, ".if_id_flush"}, 32'(if_id_flush), 32'(e_iff));
        chk({tag, ".id_ex_flush"}, 32'(id_ex_flush), 32'(e_ief));
`ifdef FETCH_SEQ_PERF_EN
        if (!r) begin
            chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_scnt));
            chk({tag, ".redirect_cnt"}, 32'(redirect_cnt), 32'(m_rcnt));
        end
`endif

        if (r) begin
            m_boot  = BOOT_CYCLES;
            m_miss  = 0;
            m_drain = 0;
            m_pend  = '0;
            m_pc    = '0;
            m_scnt  = 0;
            m_rcnt  = 0;
        end else begin
            if (!e_stall) m_pc = e_next;
            if (e_stall && !booting && m_scnt < 16'hFFFF) m_scnt++;
            if (rv && m_rcnt < 16'hFFFF) m_rcnt++;
        end

        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        current_pc   = '0;
        imem_ready   = 1'b0;
        hazard_stall = 1'b0;
        redirect_vld = 1'b0;
        redirect_pc  = '0;

        // Reset, boot, then straight-line fetch
        cyc(1, 1, 0, 0, '0, "rst");
        cyc(1, 1, 1, 1, 16'h0500, "rst_in");
        cyc(0, 1, 0, 0, '0, "boot");
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, '0, "seq");

        // Wrap past top of address space
        m_pc = 16'hFFFC;
        cyc(0, 1, 0, 0, '0, "wrap");
        chk("wrap.pc", 32'(m_pc), 32'h0);

        // Two hazard cycles, then resume
        cyc(0, 1, 1, 0, '0, "haz1");
        cyc(0, 1, 1, 0, '0, "haz2");
        cyc(0, 1, 0, 0, '0, "haz_res");

        // Redirect beats hazard
        cyc(0, 1, 1, 1, 16'h0120, "redir_haz");
        chk("redir_haz.pc", 32'(m_pc), 32'h0120);

        // Miss -> WAIT, redirect -> DRAIN, complete on cycle 3
        cyc(0, 0, 0, 0, '0, "miss");
        cyc(0, 0, 0, 1, 16'h0040, "wait_redir");
        cyc(0, 0, 0, 0, '0, "drain");
        cyc(0, 1, 0, 0, '0, "drain_done");
        chk("drain_done.pc", 32'(m_pc), 32'h0040);

        // Reset in DRAIN aborts the pending target
        cyc(0, 0, 0, 0, '0, "miss2");
        cyc(0, 0, 0, 1, 16'h0200, "wait_redir2");
        cyc(1, 0, 0, 0, '0, "rst_drain");
        cyc(0, 1, 0, 0, '0, "boot2");
        cyc(0, 1, 0, 0, '0, "post_boot");

        for (int i = 0; i < 3000; i++) begin
            bit r, rdy, haz, rv;
            logic [PC_W-1:0] rpc;
            r   = ($urandom_range(0, 99) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            haz = ($urandom_range(0, 4) == 0);
            rv  = ($urandom_range(0, 6) == 0);
            rpc = PC_W'($urandom) & 16'hFFFC;
            if ($urandom_range(0, 49) == 0) m_pc = 16'hFFFC;
            cyc(r, rdy, haz, rv, rpc, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
